conv_stream_param: RTL and testbench
====================================

// Module: conv_stream_param
// PURPOSE
//  Parametrised 1-D valid-mode convolution engine: y[n] = sum_k x[n+k]*f[k], n = 0..X_LEN-F_LEN.
//  Loads a filter and an input vector over valid/ready streams, then computes outputs with a pipelined MAC.
//  Emits outputs one at a time over a valid/ready stream.
//  Generalises the fixed 12x5 convolver: sizes and widths are parameters, an optional filter hold, an optional ReLU.
// PARAMETERS
//  WIDTH      10                                 signed bit width of x_data and f_data
//  X_LEN      12                                 input vector length (>= F_LEN)
//  F_LEN      5                                  filter length (>= 2)
//  OUT_WIDTH  2*WIDTH+$clog2(F_LEN)              signed accumulator/output width
//  KEEP_F     0                                  1 = filter is loaded once after reset and retained across vectors
// PORTS
//  clk      in   1          clock; rising edge
//  reset    in   1          asynchronous, active-high reset
//  x_data   in   WIDTH      signed input sample
//  x_valid  in   1          x_data valid
//  x_ready  out  1          block accepts x_data; transfer when x_valid & x_ready
//  f_data   in   WIDTH      signed filter coefficient
//  f_valid  in   1          f_data valid
//  f_ready  out  1          block accepts f_data; transfer when f_valid & f_ready
//  y_data   out  OUT_WIDTH  signed result
//  y_valid  out  1          y_data valid; held, with y_data stable, until y_ready
//  y_ready  in   1          consumer accepts y_data
// BEHAVIOUR
//  Reset values:
//   x_ready=1, f_ready=1, y_valid=0, y_data=0, all counters 0, state=LOAD.
//   Memory contents are don't-care.
//  State LOAD:
//   x_ready=1 until X_LEN words are accepted; f_ready=1 until F_LEN words are accepted.
//   Words are stored at addresses 0..N-1 in arrival order. Any interleaving of x and f is legal.
//   Each ready drops on the cycle after its last accepted word.
//   Beats presented while ready=0 are ignored.
//   Exit to MAC when both vectors are complete (f counts as complete if already retained).
//  State MAC (output n):
//   Reads x[n+k] and f[k] for k = 0..F_LEN-1, one pair per cycle.
//   Pipeline: memory read (1) -> registered product (1) -> accumulate.
//   Accumulator is cleared on the first product.
//   y_valid rises exactly F_LEN+2 cycles after MAC entry, then go to OUT.
//  State OUT:
//   Hold y_valid, y_data until y_ready.
//   Accept cycle with n < X_LEN-F_LEN: n++, go to MAC next cycle.
//   Accept of last output (n = X_LEN-F_LEN): go to LOAD; x_ready=1 next cycle.
//   f_ready=1 next cycle only if KEEP_F=0.
//  y_ready held high gives back-to-back outputs every F_LEN+3 cycles.
//  Arithmetic:
//   Full-precision signed WIDTH x WIDTH product, sign-extended to OUT_WIDTH.
//   Two's-complement wrap on overflow (the default OUT_WIDTH cannot overflow).
//  x_ready and f_ready are 0 throughout MAC and OUT; no load of the next vector overlaps compute.
//  Reset asserted mid-operation aborts all activity at once; outputs return to reset values.
//   A KEEP_F filter is also invalidated.
// CONFIGURATION
//  CONV_RELU_EN defined: y_data = (acc < 0) ? 0 : acc. Clamp is applied in the output register; latency unchanged.
//  CONV_RELU_EN undefined: y_data = acc (signed, may be negative).
// STRUCTURE
//  Package conv_pkg:
//   state_t enum {LOAD, MAC, OUT}
//   localparams for address widths ($clog2(X_LEN), $clog2(F_LEN)), n-counter width ($clog2(X_LEN-F_LEN+2))
//   function out_width_f(width, f_len)
//  Sub-module conv_mac:
//   registered product plus accumulator; ports clk, reset, a, b, valid_in, clear, acc_out.
//  Both storage arrays use the existing memory module (one read/write port, registered read).
// TESTING (defaults WIDTH=10, X_LEN=12, F_LEN=5)
//  1. x=1..12, f=1,1,1,1,1, y_ready=1
//     -> y = 15,20,25,30,35,40,45,50, then x_ready=f_ready=1.
//  2. x=1..12, f=-1,0,0,0,0
//     -> y = -1..-8; with CONV_RELU_EN, eight outputs all 0.
//  3. Test 1 stimulus, y_ready=0 for 10 cycles at first y_valid
//     -> y_valid stays 1, y_data stays 15, no counter advance; then 20 follows after F_LEN+3 cycles.
//  4. x all -512, f all -512
//     -> every y = 1310720 (no wrap, fits 23 bits).
//  5. Reset pulse after the 3rd output is accepted
//     -> y_valid=0 and x_ready=f_ready=1 immediately; a fresh run of test 1 is correct.
//  6. KEEP_F=1: second vector x=2..13 with f_valid held high
//     -> f_ready stays 0, no f beats accepted, y = 20,25,...,55.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the streaming convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {LOAD, MAC, OUT} state_t;

  // Default geometry of the engine.
  localparam int unsigned WIDTH_DEF = 10;
  localparam int unsigned X_LEN_DEF = 12;
  localparam int unsigned F_LEN_DEF = 5;

  // Address and output-index widths for the default geometry.
  localparam int unsigned X_AW_DEF = $clog2(X_LEN_DEF);
  localparam int unsigned F_AW_DEF = $clog2(F_LEN_DEF);
  localparam int unsigned N_W_DEF  = $clog2(X_LEN_DEF - F_LEN_DEF + 2);

  // Width that holds a sum of f_len full-precision width x width products without overflow.
  function automatic int unsigned out_width_f(input int unsigned width, input int unsigned f_len);
    return 2 * width + $clog2(f_len);
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Multiply-accumulate stage: registered signed product followed by an accumulator.
// acc_out is the running sum including the product currently in the product register.
module conv_mac #(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned OUT_WIDTH = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 valid_in,
  input  logic                 clear,
  output logic [OUT_WIDTH-1:0] acc_out
);

  localparam int unsigned PW = 2 * WIDTH;

  logic signed [PW-1:0]        prod_q;
  logic                        prod_valid_q;
  logic                        prod_clear_q;
  logic signed [OUT_WIDTH-1:0] prod_ext;
  logic signed [OUT_WIDTH-1:0] acc_q;
  logic signed [OUT_WIDTH-1:0] acc_sum;

  // Register the full-precision product together with its valid/clear tags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      prod_clear_q <= 1'b0;
    end else begin
      prod_valid_q <= valid_in;
      prod_clear_q <= valid_in && clear;
      if (valid_in) begin
        prod_q <= PW'($signed(a)) * PW'($signed(b));
      end
    end
  end

  assign prod_ext = OUT_WIDTH'(prod_q);
  // The first product of a sum replaces the old accumulator instead of adding to it.
  assign acc_sum  = prod_clear_q ? prod_ext : acc_q + prod_ext;
  assign acc_out  = acc_sum;

  // Accumulate each valid product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (prod_valid_q) begin
      acc_q <= acc_sum;
    end
  end

endmodule

// File: rtl/conv_mem.sv
// Single-port memory: one read/write port, registered read data. Contents are not reset.
module conv_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 10,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write on we; read data returns the old contents one cycle later.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/conv_stream_param.sv
// Streaming 1-D valid-mode convolution: loads x and f, then emits X_LEN-F_LEN+1 sums.
// Optional macro CONV_RELU_EN: clamp negative results to zero in the output register.
module conv_stream_param
  import conv_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned X_LEN     = X_LEN_DEF,
  parameter int unsigned F_LEN     = F_LEN_DEF,
  parameter int unsigned OUT_WIDTH = out_width_f(WIDTH, F_LEN),
  parameter bit          KEEP_F    = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     x_data,
  input  logic                 x_valid,
  output logic                 x_ready,
  input  logic [WIDTH-1:0]     f_data,
  input  logic                 f_valid,
  output logic                 f_ready,
  output logic [OUT_WIDTH-1:0] y_data,
  output logic                 y_valid,
  input  logic                 y_ready
);

  localparam int unsigned XAW = $clog2(X_LEN);
  localparam int unsigned FAW = $clog2(F_LEN);
  localparam int unsigned NW  = $clog2(X_LEN - F_LEN + 2);
  localparam int unsigned CW  = $clog2(F_LEN + 2);

  localparam logic [XAW-1:0] X_END  = XAW'(X_LEN - 1);
  localparam logic [FAW-1:0] F_END  = FAW'(F_LEN - 1);
  localparam logic [NW-1:0]  N_LAST = NW'(X_LEN - F_LEN);
  localparam logic [CW-1:0]  C_RD   = CW'(F_LEN);
  localparam logic [CW-1:0]  C_LAST = CW'(F_LEN + 1);

  state_t               state_q, state_d;
  logic                 x_done_q, f_done_q;
  logic [XAW-1:0]       x_cnt_q;
  logic [FAW-1:0]       f_cnt_q;
  logic [NW-1:0]        n_q;
  logic [CW-1:0]        c_q;
  logic                 rd_vld_q, rd_first_q;
  logic                 y_valid_q;
  logic [OUT_WIDTH-1:0] y_data_q;

  logic                 x_fire, f_fire, rd_en;
  logic [XAW-1:0]       x_addr;
  logic [FAW-1:0]       f_addr;
  logic [WIDTH-1:0]     x_rdata, f_rdata;
  logic [OUT_WIDTH-1:0] acc_sum, y_next;

  assign x_ready = (state_q == LOAD) && !x_done_q;
  assign f_ready = (state_q == LOAD) && !f_done_q;
  assign x_fire  = x_valid && x_ready;
  assign f_fire  = f_valid && f_ready;
  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;

  // Cycles 0..F_LEN-1 of MAC read one (x[n+k], f[k]) pair each; the rest drain the pipe.
  assign rd_en  = (state_q == MAC) && (c_q < C_RD);
  assign x_addr = (state_q == LOAD) ? x_cnt_q : XAW'(n_q) + XAW'(c_q);
  assign f_addr = (state_q == LOAD) ? f_cnt_q : FAW'(c_q);

  conv_mem #(.DEPTH(X_LEN), .WIDTH(WIDTH), .AW(XAW)) u_x_mem (
    .clk   (clk),
    .we    (x_fire),
    .addr  (x_addr),
    .wdata (x_data),
    .rdata (x_rdata)
  );

  conv_mem #(.DEPTH(F_LEN), .WIDTH(WIDTH), .AW(FAW)) u_f_mem (
    .clk   (clk),
    .we    (f_fire),
    .addr  (f_addr),
    .wdata (f_data),
    .rdata (f_rdata)
  );

  conv_mac #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_mac (
    .clk      (clk),
    .reset    (reset),
    .a        (x_rdata),
    .b        (f_rdata),
    .valid_in (rd_vld_q),
    .clear    (rd_first_q),
    .acc_out  (acc_sum)
  );

`ifdef CONV_RELU_EN
  assign y_next = acc_sum[OUT_WIDTH-1] ? '0 : acc_sum;
`else
  assign y_next = acc_sum;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (x_done_q && f_done_q) state_d = MAC;
      MAC:     if (c_q == C_LAST) state_d = OUT;
      OUT:     if (y_ready) state_d = (n_q == N_LAST) ? LOAD : MAC;
      default: state_d = LOAD;
    endcase
  end

  // Load counters, MAC sequencing and the output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_done_q   <= 1'b0;
      f_done_q   <= 1'b0;
      x_cnt_q    <= '0;
      f_cnt_q    <= '0;
      n_q        <= '0;
      c_q        <= '0;
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
      y_valid_q  <= 1'b0;
      y_data_q   <= '0;
    end else begin
      if (x_fire) begin
        x_cnt_q <= (x_cnt_q == X_END) ? '0 : x_cnt_q + 1'b1;
        if (x_cnt_q == X_END) x_done_q <= 1'b1;
      end
      if (f_fire) begin
        f_cnt_q <= (f_cnt_q == F_END) ? '0 : f_cnt_q + 1'b1;
        if (f_cnt_q == F_END) f_done_q <= 1'b1;
      end
      rd_vld_q   <= rd_en;
      rd_first_q <= rd_en && (c_q == '0);
      c_q        <= ((state_q == MAC) && (c_q != C_LAST)) ? c_q + 1'b1 : '0;
      // Final product is in the product register here: capture the complete sum.
      if ((state_q == MAC) && (c_q == C_LAST)) begin
        y_valid_q <= 1'b1;
        y_data_q  <= y_next;
      end
      if ((state_q == OUT) && y_ready) begin
        y_valid_q <= 1'b0;
        if (n_q == N_LAST) begin
          n_q      <= '0;
          x_done_q <= 1'b0;
          if (!KEEP_F) f_done_q <= 1'b0;
        end else begin
          n_q <= n_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_stream_param.sv
// Directed bench for conv_stream_param: dut0 reloads f per vector, dut1 retains it.
module tb_conv_stream_param;

  localparam int unsigned W    = conv_pkg::WIDTH_DEF;
  localparam int unsigned XL   = conv_pkg::X_LEN_DEF;
  localparam int unsigned FL   = conv_pkg::F_LEN_DEF;
  localparam int unsigned OW   = conv_pkg::out_width_f(W, FL);
  localparam int unsigned NOUT = XL - FL + 1;
  localparam int          GAP  = FL + 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          sel;
  logic [W-1:0]  x_data, f_data;
  logic          x_valid, f_valid, y_ready;

  logic          x_valid0, f_valid0, y_ready0, x_ready0, f_ready0, y_valid0;
  logic          x_valid1, f_valid1, y_ready1, x_ready1, f_ready1, y_valid1;
  logic [OW-1:0] y_data0, y_data1;
  logic          x_ready_m, f_ready_m, y_valid_m;
  logic [OW-1:0] y_data_m;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign x_valid0  = x_valid && !sel;
  assign f_valid0  = f_valid && !sel;
  assign y_ready0  = y_ready && !sel;
  assign x_valid1  = x_valid && sel;
  assign f_valid1  = f_valid && sel;
  assign y_ready1  = y_ready && sel;
  assign x_ready_m = sel ? x_ready1 : x_ready0;
  assign f_ready_m = sel ? f_ready1 : f_ready0;
  assign y_valid_m = sel ? y_valid1 : y_valid0;
  assign y_data_m  = sel ? y_data1 : y_data0;

  conv_stream_param #(.KEEP_F(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .x_data(x_data), .x_valid(x_valid0), .x_ready(x_ready0),
    .f_data(f_data), .f_valid(f_valid0), .f_ready(f_ready0),
    .y_data(y_data0), .y_valid(y_valid0), .y_ready(y_ready0)
  );

  conv_stream_param #(.KEEP_F(1'b1)) dut1 (
    .clk(clk), .reset(reset),
    .x_data(x_data), .x_valid(x_valid1), .x_ready(x_ready1),
    .f_data(f_data), .f_valid(f_valid1), .f_ready(f_ready1),
    .y_data(y_data1), .y_valid(y_valid1), .y_ready(y_ready1)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Stream x (with a gap every third cycle) and f concurrently; called and returns at a negedge.
  // With send_f=0 and f_hold=1, f_valid stays high and no f beat may be taken.
  task automatic load_vec(input int xs[XL], input int fs[FL], input bit send_f, input bit f_hold,
                          input string tag);
    int  xi = 0, fi = 0, cyc = 0, f_taken = 0;
    bit  xf, ff;
    while ((xi < XL || (send_f && fi < FL)) && cyc < 400) begin
      x_valid = (xi < XL) && (cyc % 3 != 1);
      x_data  = (xi < XL) ? W'(xs[xi]) : '0;
      f_valid = send_f ? (fi < FL) : f_hold;
      f_data  = (send_f && fi < FL) ? W'(fs[fi]) : W'(7);
      xf = x_valid && x_ready_m;
      ff = f_valid && f_ready_m;
      if (f_hold && !send_f) check({tag, "_f_ready_low"}, longint'(f_ready_m), 0);
      @(negedge clk);
      if (xf) xi++;
      if (ff) begin
        if (send_f) fi++;
        else f_taken++;
      end
      cyc++;
    end
    x_valid = 1'b0;
    f_valid = 1'b0;
    if (cyc >= 400) check({tag, "_load_timeout"}, 0, 1);
    if (f_hold && !send_f) check({tag, "_f_beats_taken"}, f_taken, 0);
  endtask

  // Accept outputs first..last with y_ready high; checks data and the output-to-output gap.
  task automatic collect(input longint exp[NOUT], input int first, input int last,
                         input bit gap_first, input string tag);
    int t;
    y_ready = 1'b1;
    for (int i = first; i <= last; i++) begin
      t = 0;
      while (!y_valid_m && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!y_valid_m) begin
        check($sformatf("%s_y%0d_timeout", tag, i), 0, 1);
        return;
      end
      check($sformatf("%s_y%0d", tag, i), longint'($signed(y_data_m)), exp[i]);
      if (i > first || gap_first) check($sformatf("%s_gap%0d", tag, i), t + 1, GAP);
      @(negedge clk);
    end
  endtask

  int     x_inc[XL], x_inc2[XL], x_neg[XL];
  int     f_one[FL], f_m1[FL], f_neg[FL];
  longint e_t1[NOUT], e_t2[NOUT], e_t4[NOUT], e_t6[NOUT];

  initial begin
    for (int i = 0; i < XL; i++) begin
      x_inc[i]  = i + 1;
      x_inc2[i] = i + 2;
      x_neg[i]  = -512;
    end
    for (int k = 0; k < FL; k++) begin
      f_one[k] = 1;
      f_m1[k]  = (k == 0) ? -1 : 0;
      f_neg[k] = -512;
    end
    e_t1 = '{15, 20, 25, 30, 35, 40, 45, 50};
    e_t6 = '{20, 25, 30, 35, 40, 45, 50, 55};
`ifdef CONV_RELU_EN
    e_t2 = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
    e_t2 = '{-1, -2, -3, -4, -5, -6, -7, -8};
`endif
    for (int i = 0; i < NOUT; i++) e_t4[i] = 1310720;

    reset = 1'b1; sel = 1'b0; y_ready = 1'b0;
    x_valid = 1'b0; f_valid = 1'b0; x_data = '0; f_data = '0;
    repeat (3) @(negedge clk);
    check("rst_y_valid", longint'(y_valid0), 0);
    check("rst_y_data", longint'(y_data0), 0);
    check("rst_x_ready", longint'(x_ready0), 1);
    check("rst_f_ready", longint'(f_ready0), 1);
    reset = 1'b0;
    @(negedge clk);

    // 1: box filter
    load_vec(x_inc, f_one, 1'b1, 1'b0, "t1");
    collect(e_t1, 0, NOUT - 1, 1'b0, "t1");
    check("t1_x_ready_after", longint'(x_ready_m), 1);
    check("t1_f_ready_after", longint'(f_ready_m), 1);

    // 2: negative tap
    load_vec(x_inc, f_m1, 1'b1, 1'b0, "t2");
    collect(e_t2, 0, NOUT - 1, 1'b0, "t2");

    // 3: consumer stall on the first output
    load_vec(x_inc, f_one, 1'b1, 1'b0, "t3");
    y_ready = 1'b0;
    for (int t = 0; t < 300 && !y_valid_m; t++) @(negedge clk);
    check("t3_first_valid", longint'(y_valid_m), 1);
    for (int t = 0; t < 10; t++) begin
      check($sformatf("t3_hold_valid%0d", t), longint'(y_valid_m), 1);
      check($sformatf("t3_hold_data%0d", t), longint'($signed(y_data_m)), 15);
      @(negedge clk);
    end
    y_ready = 1'b1;
    @(negedge clk);
    collect(e_t1, 1, NOUT - 1, 1'b1, "t3");

    // 4: largest-magnitude operands
    load_vec(x_neg, f_neg, 1'b1, 1'b0, "t4");
    collect(e_t4, 0, NOUT - 1, 1'b0, "t4");

    // 5: reset after the third accepted output, then a fresh run
    load_vec(x_inc, f_one, 1'b1, 1'b0, "t5");
    collect(e_t1, 0, 2, 1'b0, "t5a");
    reset = 1'b1;
    #1;
    check("t5_rst_y_valid", longint'(y_valid_m), 0);
    check("t5_rst_x_ready", longint'(x_ready_m), 1);
    check("t5_rst_f_ready", longint'(f_ready_m), 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    load_vec(x_inc, f_one, 1'b1, 1'b0, "t5b");
    collect(e_t1, 0, NOUT - 1, 1'b0, "t5b");

    // 6: retained filter on dut1
    sel = 1'b1;
    @(negedge clk);
    load_vec(x_inc, f_one, 1'b1, 1'b0, "t6a");
    collect(e_t1, 0, NOUT - 1, 1'b0, "t6a");
    check("t6_f_ready_kept", longint'(f_ready_m), 0);
    load_vec(x_inc2, f_one, 1'b0, 1'b1, "t6b");
    collect(e_t6, 0, NOUT - 1, 1'b0, "t6b");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
